// File: rtl/booth_pkg.sv
// Shared types and constants for the skip-run Booth multiplier.
// Holds the control-unit state encoding and A-register select codes.
package booth_pkg;

    localparam int N_BITS_DEF = 8;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        OP,
        DONE
    } state_t;

    localparam logic [2:0] SEL_IDLE = 3'b000;
    localparam logic [2:0] SEL_INIT = 3'b100;
    localparam logic [2:0] SEL_ADD  = 3'b001;
    localparam logic [2:0] SEL_SUB  = 3'b010;

endpackage

// File: rtl/booth_cu.sv
// Control unit for the skip-run Booth multiplier datapath.
// Sequences load, add/sub and variable shifts; keeps run statistics.
import booth_pkg::*;

module booth_cu #(
    parameter int N_BITS  = N_BITS_DEF,
    parameter int MAX_OPS = N_BITS + 1,
    parameter int CNT_W   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [CNT_W-1:0] op_count,
    output logic [CNT_W-1:0] cyc_count,
    output logic             loadA,
    output logic             shiftA,
    output logic [2:0]       selectA,
    output logic             loadM,
    output logic             loadleft,
    output logic             selectleft,
    output logic             resetleft,
    output logic             decleft,
    input  logic             xorfirsttwo,
    input  logic             secondbit,
    input  logic             amountlowerthanleft,
    input  logic             F
);

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] ops_r;
    logic [CNT_W-1:0] cyc_r;
    logic             inc_op;
    logic             abort;

    assign ready = (state == IDLE);
    assign busy  = (state == LOAD) || (state == OP);
    assign done  = (state == DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            error     <= 1'b0;
            ops_r     <= '0;
            cyc_r     <= '0;
            op_count  <= '0;
            cyc_count <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && start) begin
                error <= 1'b0;
                ops_r <= '0;
                cyc_r <= '0;
            end
            if (state == OP) begin
                if (cyc_r != '1)
                    cyc_r <= cyc_r + 1'b1;
                if (inc_op)
                    ops_r <= ops_r + 1'b1;
                if (abort)
                    error <= 1'b1;
            end
            if (state == DONE) begin
                op_count  <= ops_r;
                cyc_count <= cyc_r;
            end
        end
    end

    always_comb begin
        state_nx   = state;
        loadA      = 1'b0;
        shiftA     = 1'b0;
        selectA    = SEL_IDLE;
        loadM      = 1'b0;
        loadleft   = 1'b0;
        selectleft = 1'b0;
        resetleft  = 1'b1;
        decleft    = 1'b0;
        inc_op     = 1'b0;
        abort      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start)
                    state_nx = LOAD;
            end
            LOAD: begin
                loadA    = 1'b1;
                selectA  = SEL_INIT;
                loadM    = 1'b1;
                loadleft = 1'b1;
                state_nx = OP;
            end
            OP: begin
                // Exactly one datapath action per cycle, first match wins.
                if (F) begin
                    state_nx = DONE;
                end else if (cyc_r == CNT_W'(MAX_OPS)) begin
                    abort    = 1'b1;
                    state_nx = DONE;
                end else if (xorfirsttwo) begin
                    loadA   = 1'b1;
                    selectA = secondbit ? SEL_SUB : SEL_ADD;
                    decleft = 1'b1;
                    inc_op  = 1'b1;
                end else if (amountlowerthanleft) begin
                    shiftA     = 1'b1;
                    loadleft   = 1'b1;
                    selectleft = 1'b1;
                end else begin
                    shiftA    = 1'b1;
                    resetleft = 1'b0;
                    state_nx  = DONE;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_booth_cu.sv
// Bench for booth_cu with a behavioural skip-run Booth datapath.
// Checks products, statistics, latency, abort and reset corners.
import booth_pkg::*;

module tb_booth_cu;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       ready, busy, done, error;
    logic [3:0] op_count, cyc_count;
    logic       loadA, shiftA, loadM, loadleft;
    logic       selectleft, resetleft, decleft;
    logic [2:0] selectA;
    logic       xorfirsttwo, secondbit;
    logic       amountlowerthanleft, F;

    always #5 clk = ~clk;

    booth_cu #(.N_BITS(8), .MAX_OPS(9), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .start(start),
        .ready(ready), .busy(busy), .done(done),
        .error(error), .op_count(op_count),
        .cyc_count(cyc_count), .loadA(loadA),
        .shiftA(shiftA), .selectA(selectA),
        .loadM(loadM), .loadleft(loadleft),
        .selectleft(selectleft), .resetleft(resetleft),
        .decleft(decleft), .xorfirsttwo(xorfirsttwo),
        .secondbit(secondbit),
        .amountlowerthanleft(amountlowerthanleft),
        .F(F)
    );

    // Datapath: A = {acc(9), Q(8), q-1}, product = {acc[7:0], Q}
    logic [7:0]  in1, in2;
    logic        jam;
    logic [8:0]  acc;
    logic [7:0]  qr, mr;
    logic        q1;
    logic [3:0]  left;
    logic [17:0] a_w;
    logic [3:0]  amt;
    logic        found;
    logic [15:0] dp_out;

    assign a_w    = {acc, qr, q1};
    assign dp_out = {acc[7:0], qr};

    always_comb begin
        found = 1'b0;
        amt   = left;
        for (int i = 1; i < 9; i++) begin
            if (!found && i < int'(left) && (a_w[i] ^ a_w[i+1])) begin
                found = 1'b1;
                amt   = 4'(i);
            end
        end
    end

    assign xorfirsttwo = jam ? 1'b0 : (a_w[0] ^ a_w[1]);
    assign secondbit   = a_w[1];
    assign amountlowerthanleft = jam ? 1'b1 : found;
    assign F = jam ? 1'b0 : (left == 4'd0);

    always @(posedge clk) begin
        logic [8:0]  msx;
        logic [17:0] t;
        msx = {mr[7], mr};
        if (loadA) begin
            if (selectA == SEL_INIT) begin
                acc <= '0; qr <= in1; q1 <= 1'b0;
            end else begin
                t = {(selectA == SEL_SUB) ? acc - msx : acc + msx,
                     qr, q1};
                t = 18'($signed(t) >>> 1);
                {acc, qr, q1} <= t;
            end
        end else if (shiftA) begin
            t = 18'($signed(a_w) >>> (resetleft ? amt : left));
            {acc, qr, q1} <= t;
        end
        if (loadM) mr <= in2;
        if (!resetleft) left <= '0;
        else if (loadleft) left <= selectleft ? left - amt : 4'd8;
        else if (decleft) left <= left - 4'd1;
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input longint act,
                       input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: walk Booth pairs of the multiplier, skipping runs.
    function automatic void ref_model(input logic [7:0] a,
                                      input logic [7:0] b,
                                      output logic [15:0] p,
                                      output int ops,
                                      output int k);
        logic [8:0] ab;
        int pos, nxt;
        bit ended;
        p = 16'($signed(a) * $signed(b));
        ab = {a, 1'b0};
        ops = 0; k = 0; pos = 0; ended = 0;
        while (pos < 8) begin
            if (ab[pos] ^ ab[pos+1]) begin
                ops++; k++; pos++;
            end else begin
                nxt = 8;
                for (int j = 8; j > pos; j--)
                    if (j < 8 && (ab[j] ^ ab[j+1])) nxt = j;
                k++;
                if (nxt == 8) ended = 1;
                pos = nxt;
            end
        end
        if (!ended) k++;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_mul(input logic [7:0] a, input logic [7:0] b,
                           output int lat, output logic [15:0] p);
        bit got;
        in1 = a; in2 = b; start = 1'b1;
        lat = 0; p = 'x; got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            tick();
            start = 1'b0;
            lat++;
            if (done) begin
                got = 1;
                p = dp_out;
            end
        end
        if (!got) chk("done_timeout", 0, 1);
        tick();
    endtask

    task automatic check_vec(input string nm, input logic [7:0] a,
                             input logic [7:0] b, input logic [15:0] ep,
                             input int eops, input int ek);
        int lat;
        logic [15:0] p;
        run_mul(a, b, lat, p);
        chk({nm, "_out"}, p, ep);
        chk({nm, "_ops"}, op_count, eops);
        chk({nm, "_cyc"}, cyc_count, ek);
        chk({nm, "_lat"}, lat, ek + 2);
        chk({nm, "_err"}, error, 0);
    endtask

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] p;
        int          ops;
        int          k;
    } vec_t;

    vec_t vt[6];

    initial begin
        int lat, n, ops, k;
        logic [15:0] p;
        logic [7:0] ra, rb;
        vt[0] = '{8'h00, 8'h05, 16'h0000, 0, 1};
        vt[1] = '{8'h03, 8'h07, 16'h0015, 2, 4};
        vt[2] = '{8'hFF, 8'hFF, 16'h0001, 1, 2};
        vt[3] = '{8'h55, 8'h03, 16'h00FF, 8, 9};
        vt[4] = '{8'h80, 8'h80, 16'h4000, 1, 3};
        vt[5] = '{8'h01, 8'h80, 16'hFF80, 2, 3};

        reset = 1'b1; start = 1'b0; jam = 1'b0;
        in1 = '0; in2 = '0;
        tick(); tick();
        reset = 1'b0;
        chk("rst_ready", ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_resetleft", resetleft, 1);
        chk("rst_cmds", {loadA, shiftA, loadM, loadleft,
                         decleft, selectA}, 0);
        chk("rst_counts", {op_count, cyc_count}, 0);

        for (int i = 0; i < 6; i++)
            check_vec($sformatf("vec%0d", i), vt[i].a, vt[i].b,
                      vt[i].p, vt[i].ops, vt[i].k);

        for (int i = 0; i < 24; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            ref_model(ra, rb, p, ops, k);
            check_vec($sformatf("rnd%0d", i), ra, rb, p, ops, k);
        end

        // start pulsed mid-operation is ignored
        in1 = 8'h55; in2 = 8'h03; start = 1'b1;
        tick(); start = 1'b0;
        tick(); tick();
        start = 1'b1;
        tick(); start = 1'b0;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) n++;
            tick();
        end
        chk("ign_done_count", n, 1);
        chk("ign_idle", {ready, busy}, 2'b10);
        check_vec("after_ign", 8'h03, 8'h07, 16'h0015, 2, 4);

        // start held high: back-to-back multiplies
        in1 = 8'h00; in2 = 8'h05; start = 1'b1;
        n = 0;
        for (int i = 0; i < 20 && !done; i++) tick();
        chk("held_first", done, 1);
        tick();
        for (int i = 0; i < 20 && !done; i++) begin
            tick(); n++;
        end
        start = 1'b0;
        chk("held_gap", n, 3);
        tick(); tick();

        // reset in the second OP cycle
        in1 = 8'h55; in2 = 8'h03; start = 1'b1;
        tick(); start = 1'b0;
        tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_ready", ready, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_resetleft", resetleft, 1);
        chk("midrst_cmds", {loadA, shiftA, loadM, loadleft,
                            decleft, selectleft, selectA}, 0);
        chk("midrst_counts", {op_count, cyc_count}, 0);
        n = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) n++;
            tick();
        end
        chk("midrst_nodone", n, 0);
        check_vec("after_rst", 8'hFF, 8'hFF, 16'h0001, 1, 2);

        // runaway guard: flags never terminate the run
        jam = 1'b1;
        run_mul(8'h00, 8'h01, lat, p);
        jam = 1'b0;
        chk("abort_lat", lat, 12);
        chk("abort_err", error, 1);
        chk("abort_cyc", cyc_count, 10);
        chk("abort_ops", op_count, 0);
        tick();
        chk("abort_sticky", error, 1);
        check_vec("after_abort", 8'h55, 8'h03, 16'h00FF, 8, 9);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
